// File: rtl/serial_add_ctrl.sv
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial adder (LSB first, one bit per clock) with
//               IDLE/ADD/DONE control and registered sum/carry outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             Cout
);

    localparam int             c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  r_a_sh;
    logic [WIDTH-1:0]  r_b_sh;
    logic [WIDTH-1:0]  r_sum_sh;
    logic              r_carry;
    logic [c_CW-1:0]   r_cnt;

    logic              w_ha1_s;
    logic              w_ha1_c;
    logic              w_sum;
    logic              w_ha2_c;
    logic              w_carry_next;
    logic              w_last;
    logic [WIDTH:0]    w_sum_cat;
    logic [WIDTH-1:0]  w_sum_next;

    // Full adder from two half adders and an OR gate
    assign w_ha1_s      = r_a_sh[0] ^ r_b_sh[0];
    assign w_ha1_c      = r_a_sh[0] & r_b_sh[0];
    assign w_sum        = w_ha1_s ^ r_carry;
    assign w_ha2_c      = w_ha1_s & r_carry;
    assign w_carry_next = w_ha1_c | w_ha2_c;

    // Concatenate then drop the LSB so the shift also works for WIDTH == 1
    assign w_sum_cat  = {w_sum, r_sum_sh};
    assign w_sum_next = w_sum_cat[WIDTH:1];
    assign w_last     = (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = ADD;
                end
            end
            ADD: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            s        <= '0;
            Cout     <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                r_a_sh   <= a;
                r_b_sh   <= b;
                r_sum_sh <= '0;
                r_carry  <= 1'b0;
                r_cnt    <= '0;
            end else if (r_state == ADD) begin
                r_a_sh   <= r_a_sh >> 1;
                r_b_sh   <= r_b_sh >> 1;
                r_sum_sh <= w_sum_next;
                r_carry  <= w_carry_next;
                r_cnt    <= r_cnt + c_CW'(1);
                if (w_last) begin
                    s    <= w_sum_next;
                    Cout <= w_carry_next;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Directed self-checking bench for serial_add_ctrl (WIDTH=8)
//               with a cycle-level reference model and per-cycle compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         Cout;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .Cout  (Cout)
    );

    always #5 clk = ~clk;

    // Reference model: phase = edges since the accept edge, -1 when idle
    int           m_phase = -1;
    logic [W:0]   m_sum   = '0;
    logic [W-1:0] m_s     = '0;
    logic         m_c     = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= -1;
            m_s     <= '0;
            m_c     <= 1'b0;
        end else if (m_phase < 0) begin
            if (start) begin
                m_phase <= 0;
                m_sum   <= {1'b0, a} + {1'b0, b};
            end
        end else begin
            if (m_phase == W) m_phase <= -1;
            else              m_phase <= m_phase + 1;
            if (m_phase == W - 1) begin
                m_s <= m_sum[W-1:0];
                m_c <= m_sum[W];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_busy", 32'(busy), 32'(m_phase >= 0));
            chk("cmp_done", 32'(done), 32'(m_phase == W));
            chk("cmp_s",    32'(s),    32'(m_s));
            chk("cmp_cout", 32'(Cout), 32'(m_c));
        end
    end

    // One operation: returns edges to done, busy cycles and done pulses seen
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input bit disturb,
                          output int lat, output int bc, output int dc);
        @(posedge clk); #1;
        start = 1'b1; a = ia; b = ib;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; dc = 0;
        @(negedge clk);
        bc = busy ? 1 : 0;
        for (int n = 1; n <= 20; n++) begin
            if (disturb) begin
                a = W'($urandom); b = W'($urandom);
                start = (n == 3);
            end
            @(posedge clk);
            @(negedge clk);
            if (busy) bc++;
            if (done) begin
                dc++;
                if (lat < 0) lat = n;
            end
            if (!busy) break;
        end
        start = 1'b0;
    endtask

    task automatic op_check(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                            input logic [W-1:0] es, input logic ec, input bit disturb);
        int lat, bc, dc;
        run_op(ia, ib, disturb, lat, bc, dc);
        chk({tag, "_latency"}, 32'(lat), 32'(W));
        chk({tag, "_busycyc"}, 32'(bc), 32'(W + 1));
        chk({tag, "_donecnt"}, 32'(dc), 32'd1);
        chk({tag, "_s"}, 32'(s), 32'(es));
        chk({tag, "_cout"}, 32'(Cout), 32'(ec));
    endtask

    initial begin
        int edges, ndone;
        int dpos[3];
        logic [W-1:0] exp_s[3];
        logic         exp_c[3];
        logic [W-1:0] op_a[3];
        logic [W-1:0] op_b[3];

        #3 rst_n = 1'b0;
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_s",    32'(s),    32'd0);
        chk("rst_cout", 32'(Cout), 32'd0);
        #2 rst_n = 1'b1;

        op_check("zero", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        op_check("a5_5a", 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0);
        op_check("ff_01", 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        op_check("ff_ff", 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0);
        op_check("ignore", 8'h12, 8'h34, 8'h46, 1'b0, 1'b1);

        // Start held high: three back-to-back operations
        op_a = '{8'h10, 8'h80, 8'h7F};
        op_b = '{8'h20, 8'h80, 8'h01};
        exp_s = '{8'h30, 8'h00, 8'h80};
        exp_c = '{1'b0, 1'b1, 1'b0};
        @(posedge clk); #1;
        start = 1'b1; a = op_a[0]; b = op_b[0];
        ndone = 0;
        for (edges = 1; edges <= 50 && ndone < 3; edges++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                dpos[ndone] = edges;
                chk("held_s", 32'(s), 32'(exp_s[ndone]));
                chk("held_cout", 32'(Cout), 32'(exp_c[ndone]));
                ndone++;
                if (ndone < 3) begin
                    a = op_a[ndone]; b = op_b[ndone];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("held_ndone", 32'(ndone), 32'd3);
        if (ndone == 3) begin
            chk("held_gap1", 32'(dpos[1] - dpos[0]), 32'd10);
            chk("held_gap2", 32'(dpos[2] - dpos[1]), 32'd10);
        end
        repeat (3) @(posedge clk);

        // Asynchronous reset in the middle of bit 4
        @(posedge clk); #1;
        start = 1'b1; a = 8'h33; b = 8'h44;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_s",    32'(s),    32'd0);
        chk("midrst_cout", 32'(Cout), 32'd0);
        ndone = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) ndone++;
        end
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midrst_nodone", 32'(ndone), 32'd0);
        op_check("after_rst", 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
